decode_stage: RTL and testbench

- Second pipeline stage; consumes instruction_D / PC_D from the fetch stage's IF/ID register.
- Decodes RV32I base instructions, reads the 32x32 register file, generates the sign-extended immediate and detects load-use hazards.
- Registers all results into the ID/EX pipeline register; outputs carry the _E suffix.
- Accepts the writeback port from the WB stage.

---
 rtl/riscv_pkg.sv | 90 +++++++++
 rtl/reg_file.sv | 44 ++++
 rtl/decode_stage.sv | 170 +++++++++++++++++
 tb/tb_decode_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I decode constants, ID/EX record and ALU-op helper
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // Writeback result source
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // funct3: branches
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    // funct3: loads / stores
    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_ctrl;
        logic            alu_src;
        logic [1:0]      result_src;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic [2:0]      funct3;
        logic            illegal;
    } id_ex_t;

    // ALU op for OP / OP-IMM. inst[30] selects SUB only for register-register
    // adds (ADDI has no subtract form), but selects SRA for both SRA and SRAI.
    function automatic logic [3:0] alu_op_decode(input logic [2:0] f3,
                                                 input logic       bit30,
                                                 input logic       is_reg_op);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_reg_op && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, 2 async reads, 1 write, x0 zero, write-through bypass
// Ports: clock/reset (async active-high), raddr1/raddr2 -> rdata1/rdata2,
//        we/waddr/wdata write port committed on the rising edge.
import riscv_pkg::*;

module reg_file #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Bypass lets an instruction in decode see the value being written back
    // this same cycle, so WB->ID needs no extra forwarding path.
    always_comb begin
        rdata1 = regs_q[raddr1];
        rdata2 = regs_q[raddr2];
        if (we && (waddr != 5'd0) && (waddr == raddr1)) rdata1 = wdata;
        if (we && (waddr != 5'd0) && (waddr == raddr2)) rdata2 = wdata;
        if (raddr1 == 5'd0) rdata1 = '0;
        if (raddr2 == 5'd0) rdata2 = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: decode, regfile read, immediates, load-use hazard, ID/EX register
// Ports: clock/reset (async active-high); instruction_D/PC_D from IF/ID;
//        flush_E bubble request; reg_write_W/rd_W/result_W writeback;
//        load_use_stall (combinational) to fetch; *_E registered ID/EX outputs.
import riscv_pkg::*;

module decode_stage #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     instruction_D,
    input  logic [XLEN-1:0] PC_D,
    input  logic            flush_E,
    input  logic            reg_write_W,
    input  logic [4:0]      rd_W,
    input  logic [XLEN-1:0] result_W,
    output logic            load_use_stall,
    output logic [XLEN-1:0] PC_E,
    output logic [XLEN-1:0] rs1_data_E,
    output logic [XLEN-1:0] rs2_data_E,
    output logic [XLEN-1:0] imm_E,
    output logic [4:0]      rs1_E,
    output logic [4:0]      rs2_E,
    output logic [4:0]      rd_E,
    output logic [3:0]      alu_ctrl_E,
    output logic            alu_src_E,
    output logic [1:0]      result_src_E,
    output logic            reg_write_E,
    output logic            mem_read_E,
    output logic            mem_write_E,
    output logic            branch_E,
    output logic            jump_E,
    output logic            jalr_E,
    output logic [2:0]      funct3_E,
    output logic            illegal_E
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    id_ex_t          dec;
    id_ex_t          id_ex_d;
    id_ex_t          id_ex_q;

    assign opcode = instruction_D[6:0];
    assign f3     = instruction_D[14:12];

    assign imm_i = {{20{instruction_D[31]}}, instruction_D[31:20]};
    assign imm_s = {{20{instruction_D[31]}}, instruction_D[31:25], instruction_D[11:7]};
    assign imm_b = {{20{instruction_D[31]}}, instruction_D[7], instruction_D[30:25],
                    instruction_D[11:8], 1'b0};
    assign imm_u = {instruction_D[31:12], 12'b0};
    assign imm_j = {{12{instruction_D[31]}}, instruction_D[19:12], instruction_D[20],
                    instruction_D[30:21], 1'b0};

    assign uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    assign uses_rs2 = (opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_OP);

    // Unused source fields are steered to x0 so they read zero and never
    // trigger forwarding in EX.
    assign rs1_idx = uses_rs1 ? instruction_D[19:15] : 5'd0;
    assign rs2_idx = uses_rs2 ? instruction_D[24:20] : 5'd0;

    reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_reg_file (
        .clock  (clock),
        .reset  (reset),
        .raddr1 (rs1_idx),
        .raddr2 (rs2_idx),
        .rdata1 (rs1_rdata),
        .rdata2 (rs2_rdata),
        .we     (reg_write_W),
        .waddr  (rd_W),
        .wdata  (result_W)
    );

    assign load_use_stall = id_ex_q.mem_read && (id_ex_q.rd != 5'd0) &&
                            (((id_ex_q.rd == instruction_D[19:15]) && uses_rs1) ||
                             ((id_ex_q.rd == instruction_D[24:20]) && uses_rs2));

    always_comb begin
        dec          = '0;
        dec.pc       = PC_D;
        dec.rs1      = rs1_idx;
        dec.rs2      = rs2_idx;
        dec.rd       = instruction_D[11:7];
        dec.rs1_data = rs1_rdata;
        dec.rs2_data = rs2_rdata;
        dec.funct3   = f3;
        dec.alu_ctrl = ALU_ADD;
        case (opcode)
            OP_LUI: begin
                dec.imm = imm_u; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.alu_ctrl = ALU_PASSB;
            end
            OP_AUIPC: begin
                dec.imm = imm_u; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
            end
            OP_JAL: begin
                dec.imm = imm_j; dec.reg_write = 1'b1; dec.jump = 1'b1;
                dec.result_src = RES_PC4;
            end
            OP_JALR: begin
                dec.imm = imm_i; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.jump = 1'b1; dec.jalr = 1'b1; dec.result_src = RES_PC4;
            end
            OP_BRANCH: begin
                dec.imm = imm_b; dec.branch = 1'b1;
            end
            OP_LOAD: begin
                dec.imm = imm_i; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.mem_read = 1'b1; dec.result_src = RES_MEM;
            end
            OP_STORE: begin
                dec.imm = imm_s; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
            end
            OP_IMM: begin
                dec.imm = imm_i; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.alu_ctrl = alu_op_decode(f3, instruction_D[30], 1'b0);
            end
            OP_OP: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl = alu_op_decode(f3, instruction_D[30], 1'b1);
            end
            default: dec.illegal = 1'b1;
        endcase

        // All-zero is the IF/ID reset fill, not a real illegal instruction.
        if (flush_E || load_use_stall || (instruction_D == 32'h0)) begin
            id_ex_d = '0;
        end else begin
            id_ex_d = dec;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign PC_E         = id_ex_q.pc;
    assign rs1_data_E   = id_ex_q.rs1_data;
    assign rs2_data_E   = id_ex_q.rs2_data;
    assign imm_E        = id_ex_q.imm;
    assign rs1_E        = id_ex_q.rs1;
    assign rs2_E        = id_ex_q.rs2;
    assign rd_E         = id_ex_q.rd;
    assign alu_ctrl_E   = id_ex_q.alu_ctrl;
    assign alu_src_E    = id_ex_q.alu_src;
    assign result_src_E = id_ex_q.result_src;
    assign reg_write_E  = id_ex_q.reg_write;
    assign mem_read_E   = id_ex_q.mem_read;
    assign mem_write_E  = id_ex_q.mem_write;
    assign branch_E     = id_ex_q.branch;
    assign jump_E       = id_ex_q.jump;
    assign jalr_E       = id_ex_q.jalr;
    assign funct3_E     = id_ex_q.funct3;
    assign illegal_E    = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

    logic        clock;
    logic        reset;
    logic [31:0] instruction_D;
    logic [31:0] PC_D;
    logic        flush_E;
    logic        reg_write_W;
    logic [4:0]  rd_W;
    logic [31:0] result_W;
    logic        load_use_stall;
    logic [31:0] PC_E, rs1_data_E, rs2_data_E, imm_E;
    logic [4:0]  rs1_E, rs2_E, rd_E;
    logic [3:0]  alu_ctrl_E;
    logic        alu_src_E;
    logic [1:0]  result_src_E;
    logic        reg_write_E, mem_read_E, mem_write_E, branch_E, jump_E, jalr_E;
    logic [2:0]  funct3_E;
    logic        illegal_E;

    int n_checks = 0;
    int n_pass   = 0;

    decode_stage dut (
        .clock          (clock),
        .reset          (reset),
        .instruction_D  (instruction_D),
        .PC_D           (PC_D),
        .flush_E        (flush_E),
        .reg_write_W    (reg_write_W),
        .rd_W           (rd_W),
        .result_W       (result_W),
        .load_use_stall (load_use_stall),
        .PC_E           (PC_E),
        .rs1_data_E     (rs1_data_E),
        .rs2_data_E     (rs2_data_E),
        .imm_E          (imm_E),
        .rs1_E          (rs1_E),
        .rs2_E          (rs2_E),
        .rd_E           (rd_E),
        .alu_ctrl_E     (alu_ctrl_E),
        .alu_src_E      (alu_src_E),
        .result_src_E   (result_src_E),
        .reg_write_E    (reg_write_E),
        .mem_read_E     (mem_read_E),
        .mem_write_E    (mem_write_E),
        .branch_E       (branch_E),
        .jump_E         (jump_E),
        .jalr_E         (jalr_E),
        .funct3_E       (funct3_E),
        .illegal_E      (illegal_E)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset         = 1'b1;
        instruction_D = 32'h0;
        PC_D          = 32'h0;
        flush_E       = 1'b0;
        reg_write_W   = 1'b0;
        rd_W          = 5'd0;
        result_W      = 32'h0;
        repeat (2) @(negedge clock);

        check("rst_stall",     {31'b0, load_use_stall}, 32'h0);
        check("rst_pc",        PC_E, 32'h0);
        check("rst_reg_write", {31'b0, reg_write_E}, 32'h0);
        check("rst_illegal",   {31'b0, illegal_E}, 32'h0);
        reset = 1'b0;

        // Writeback x1=5 bypassed into add x2,x1,x1 in the same cycle
        reg_write_W = 1'b1; rd_W = 5'd1; result_W = 32'd5;
        instruction_D = 32'h00108133; PC_D = 32'h10;
        cycle();
        check("add_rs1_data",  rs1_data_E, 32'd5);
        check("add_rs2_data",  rs2_data_E, 32'd5);
        check("add_alu",       {28'b0, alu_ctrl_E}, 32'd0);
        check("add_reg_write", {31'b0, reg_write_E}, 32'd1);
        check("add_rd",        {27'b0, rd_E}, 32'd2);
        check("add_pc",        PC_E, 32'h10);

        // Writes to x0 are dropped, with and without bypass
        rd_W = 5'd0; result_W = 32'hDEADBEEF;
        instruction_D = 32'h00000033;
        cycle();
        check("x0_bypass",     rs1_data_E, 32'h0);
        reg_write_W = 1'b0;
        cycle();
        check("x0_read",       rs1_data_E, 32'h0);

        // lw x3,0(x1) then add x4,x3,x3: one stall cycle, writeback during stall lands
        instruction_D = 32'h0000A183; PC_D = 32'h20;
        cycle();
        check("lw_mem_read",   {31'b0, mem_read_E}, 32'd1);
        check("lw_rd",         {27'b0, rd_E}, 32'd3);
        check("lw_result_src", {30'b0, result_src_E}, 32'd1);
        check("lw_rs1_data",   rs1_data_E, 32'd5);
        instruction_D = 32'h00318233; PC_D = 32'h24;
        reg_write_W = 1'b1; rd_W = 5'd3; result_W = 32'd7;
        #1;
        check("lu_stall_on",   {31'b0, load_use_stall}, 32'd1);
        cycle();
        reg_write_W = 1'b0;
        #1;
        check("lu_stall_off",  {31'b0, load_use_stall}, 32'd0);
        check("lu_bubble_rw",  {31'b0, reg_write_E}, 32'd0);
        check("lu_bubble_rd",  {27'b0, rd_E}, 32'd0);
        check("lu_bubble_pc",  PC_E, 32'h0);
        cycle();
        check("lu_add_rd",     {27'b0, rd_E}, 32'd4);
        check("lu_add_rw",     {31'b0, reg_write_E}, 32'd1);
        check("lu_add_rs1",    rs1_data_E, 32'd7);
        check("lu_add_rs2",    rs2_data_E, 32'd7);
        check("lu_add_pc",     PC_E, 32'h24);

        // beq x0,x0,-8 at 0x40, then flushed
        instruction_D = 32'hFE000CE3; PC_D = 32'h40;
        cycle();
        check("beq_imm",       imm_E, 32'hFFFFFFF8);
        check("beq_branch",    {31'b0, branch_E}, 32'd1);
        check("beq_reg_write", {31'b0, reg_write_E}, 32'd0);
        check("beq_pc",        PC_E, 32'h40);
        flush_E = 1'b1;
        cycle();
        check("flush_branch",  {31'b0, branch_E}, 32'd0);
        check("flush_pc",      PC_E, 32'h0);
        flush_E = 1'b0;

        // Illegal opcode
        instruction_D = 32'hFFFFFFFF; PC_D = 32'h50;
        cycle();
        check("ill_flag",      {31'b0, illegal_E}, 32'd1);
        check("ill_reg_write", {31'b0, reg_write_E}, 32'd0);
        check("ill_mem_write", {31'b0, mem_write_E}, 32'd0);
        check("ill_mem_read",  {31'b0, mem_read_E}, 32'd0);

        // lui x0,0x12345
        instruction_D = 32'h12345037; PC_D = 32'h54;
        cycle();
        check("lui_imm",       imm_E, 32'h12345000);
        check("lui_alu",       {28'b0, alu_ctrl_E}, 32'd10);
        check("lui_illegal",   {31'b0, illegal_E}, 32'd0);

        // sub x0,x1,x2
        instruction_D = 32'h40208033; PC_D = 32'h58;
        cycle();
        check("sub_alu",       {28'b0, alu_ctrl_E}, 32'd1);

        // srai x1,x1,3
        instruction_D = 32'h4030D093; PC_D = 32'h5C;
        cycle();
        check("srai_alu",      {28'b0, alu_ctrl_E}, 32'd7);
        check("srai_alu_src",  {31'b0, alu_src_E}, 32'd1);
        check("srai_imm",      imm_E, 32'h403);

        // jal x1,8
        instruction_D = 32'h008000EF; PC_D = 32'h60;
        cycle();
        check("jal_imm",       imm_E, 32'd8);
        check("jal_jump",      {31'b0, jump_E}, 32'd1);
        check("jal_res_src",   {30'b0, result_src_E}, 32'd2);

        // All-zero reset fill is a bubble, not illegal
        instruction_D = 32'h0; PC_D = 32'h64;
        cycle();
        check("zero_illegal",  {31'b0, illegal_E}, 32'd0);
        check("zero_rw",       {31'b0, reg_write_E}, 32'd0);

        // x5=9, then add x6,x5,x3; reset mid-cycle clears ID/EX and regfile
        reg_write_W = 1'b1; rd_W = 5'd5; result_W = 32'd9;
        instruction_D = 32'h00328333; PC_D = 32'h80;
        cycle();
        reg_write_W = 1'b0;
        check("pre_rst_rs1",   rs1_data_E, 32'd9);
        check("pre_rst_rs2",   rs2_data_E, 32'd7);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_rs1",   rs1_data_E, 32'h0);
        check("mid_rst_rw",    {31'b0, reg_write_E}, 32'd0);
        check("mid_rst_rd",    {27'b0, rd_E}, 32'd0);
        check("mid_rst_pc",    PC_E, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        cycle();
        check("post_rst_x5",   rs1_data_E, 32'h0);
        check("post_rst_x3",   rs2_data_E, 32'h0);
        check("post_rst_rd",   {27'b0, rd_E}, 32'd6);
        check("post_rst_rw",   {31'b0, reg_write_E}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
